apb_wait_slave: RTL and testbench

APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_regfile.sv | 38 +++
 rtl/apb_wait_slave.sv | 186 ++++++++++++++++++
 tb/tb_apb_wait_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB wait-state completer: FSM state encoding,
// the registered pready/pslverr response pair and the wait-counter width.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_t;

    // Response as driven onto the bus: ready marks completion, slverr the error flag.
    typedef struct packed {
        logic ready;
        logic slverr;
    } apb_resp_t;

    localparam apb_resp_t RESP_NONE = '{ready: 1'b0, slverr: 1'b0};
    localparam apb_resp_t RESP_OKAY = '{ready: 1'b1, slverr: 1'b0};
    localparam apb_resp_t RESP_ERR  = '{ready: 1'b1, slverr: 1'b1};

    // Wait-state counter holds 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W storage with one byte-enabled synchronous write port,
// one combinational read port and an asynchronous active-low clear.
module apb_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every word on reset; otherwise merge enabled byte lanes into the addressed word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a fixed number of wait states per transfer, backed by
// an apb_regfile. Address decode, the IDLE/WAIT/DONE FSM and the registered
// response live here.
// Optional feature: define APB_PSTRB_EN to add the pstrb port and byte-lane
// write masking; without it every legal write updates the whole word.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int                    APB_BUS_W   = 32,
    parameter int                    APB_ADDR_W  = 32,
    parameter int                    DEPTH       = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [APB_ADDR_W-1:0]   paddr,
    input  logic [APB_BUS_W-1:0]    pwdata,
`ifdef APB_PSTRB_EN
    input  logic [APB_BUS_W/8-1:0]  pstrb,
`endif
    output logic [APB_BUS_W-1:0]    prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int BE_W  = APB_BUS_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [APB_ADDR_W:0]   SPAN       = (APB_ADDR_W+1)'(DEPTH * BE_W);
    localparam logic [APB_ADDR_W-1:0] ALIGN_MASK = APB_ADDR_W'(BE_W - 1);
    localparam logic [CNT_W-1:0]      WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

    // Legal = inside the window starting at BASE_ADDR and word aligned.
    function automatic logic addr_legal(input logic [APB_ADDR_W-1:0] a);
        logic [APB_ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN) && ((off & ALIGN_MASK) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [APB_ADDR_W-1:0] a);
        logic [APB_ADDR_W-1:0] off;
        off = (a - BASE_ADDR) >> OFF_W;
        return off[IDX_W-1:0];
    endfunction

    apb_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic                  write_q;
    logic                  legal_q;
    logic [IDX_W-1:0]      idx_q;
    logic [APB_BUS_W-1:0]  wdata_q;
    logic [BE_W-1:0]       strb_q;
    apb_resp_t             resp_q;
    logic [APB_BUS_W-1:0]  prdata_q;

    logic                  setup_phase;
    logic                  access_phase;
    logic                  go_setup;
    logic                  finish_now;
    logic                  finish_wait;
    logic                  finish;
    logic                  commit;
    logic                  cur_legal;
    logic [IDX_W-1:0]      cur_idx;
    logic                  fin_write;
    logic                  fin_legal;
    logic [IDX_W-1:0]      fin_idx;
    logic [BE_W-1:0]       strb_in;
    logic [APB_BUS_W-1:0]  rf_rdata;
    logic [APB_BUS_W-1:0]  fwd_word;

`ifdef APB_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    assign setup_phase  = psel && !penable;
    assign access_phase = psel && penable;
    assign cur_legal    = addr_legal(paddr);
    assign cur_idx      = addr_index(paddr);

    // With no wait states a setup phase heads straight for DONE, so the
    // completing transfer is still on the bus rather than in the latches.
    assign go_setup    = setup_phase && (state == ST_IDLE || state == ST_DONE);
    assign finish_now  = go_setup && (WAIT_CYCLES == 0);
    assign finish_wait = (state == ST_WAIT) && access_phase && (cnt == CNT_W'(1));
    assign finish      = finish_now || finish_wait;

    assign fin_write = finish_now ? pwrite    : write_q;
    assign fin_legal = finish_now ? cur_legal : legal_q;
    assign fin_idx   = finish_now ? cur_idx   : idx_q;

    // Storage is written on the edge that closes DONE.
    assign commit = (state == ST_DONE) && write_q && legal_q;

    apb_regfile #(
        .DATA_W (APB_BUS_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (commit),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .wr_be   (strb_q),
        .rd_idx  (fin_idx),
        .rd_data (rf_rdata)
    );

    // A back-to-back read of the word being committed this edge must see the new bytes.
    always_comb begin
        fwd_word = rf_rdata;
        if (commit && (idx_q == fin_idx)) begin
            for (int b = 0; b < BE_W; b++) begin
                if (strb_q[b]) begin
                    fwd_word[b*8 +: 8] = wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // Transfer FSM: latch the request at setup, count access cycles, and register the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            write_q  <= 1'b0;
            legal_q  <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            resp_q   <= RESP_NONE;
            prdata_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (setup_phase) begin
                        write_q <= pwrite;
                        legal_q <= cur_legal;
                        idx_q   <= cur_idx;
                        wdata_q <= pwdata;
                        strb_q  <= strb_in;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (penable) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase

            if (finish) begin
                resp_q   <= fin_legal ? RESP_OKAY : RESP_ERR;
                prdata_q <= (fin_legal && !fin_write) ? fwd_word : '0;
            end else begin
                resp_q   <= RESP_NONE;
                prdata_q <= '0;
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = resp_q.ready;
    assign pslverr = resp_q.slverr;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: two instances (0 and 3 wait states) at base 0x1000,
// driven one at a time; expected responses queue up per instance and are
// retired by a monitor whenever pready is seen.
`timescale 1ns/1ps
module tb_apb_wait_slave;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WC0   = 0;
    localparam int          WC1   = 3;
`ifdef APB_PSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset_n;
    logic [1:0]       psel;
    logic [1:0]       penable;
    logic [1:0]       pwrite;
    logic [1:0][31:0] paddr;
    logic [1:0][31:0] pwdata;
    logic [1:0][3:0]  pstrb;
    logic [1:0][31:0] prdata;
    logic [1:0]       pready;
    logic [1:0]       pslverr;

    apb_wait_slave #(.APB_BUS_W(32), .APB_ADDR_W(32), .DEPTH(DEPTH),
                     .WAIT_CYCLES(WC0), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .reset_n(reset_n[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb[0]),
`endif
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_wait_slave #(.APB_BUS_W(32), .APB_ADDR_W(32), .DEPTH(DEPTH),
                     .WAIT_CYCLES(WC1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .reset_n(reset_n[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb[1]),
`endif
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    int total  = 0;
    int passed = 0;

    logic [31:0] mem_m [2][DEPTH];
    exp_t q0[$];
    exp_t q1[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endfunction

    function automatic int wc(int d);
        return (d == 0) ? WC0 : WC1;
    endfunction

    function automatic bit legal_m(logic [31:0] a);
        return (a >= BASE) && (a < BASE + DEPTH * 4) && ((a % 4) == 0);
    endfunction

    function automatic void push_exp(int d, exp_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop_exp(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void clear_model(int d);
        for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
    endfunction

    // Monitor: every sampled pready retires the oldest expectation; otherwise prdata must be 0.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset_n[d]) begin
                if (pready[d]) begin
                    if (qsize(d) == 0) begin
                        chk($sformatf("spurious_pready_dut%0d", d), {31'b0, pready[d]}, 32'd0);
                    end else begin
                        exp_t e;
                        e = pop_exp(d);
                        chk($sformatf("prdata_dut%0d", d), prdata[d], e.data);
                        chk($sformatf("pslverr_dut%0d", d), {31'b0, pslverr[d]}, {31'b0, e.err});
                    end
                end else begin
                    chk($sformatf("prdata_not_ready_dut%0d", d), prdata[d], 32'd0);
                end
            end
        end
    end

    // One complete transfer; b2b=1 means the caller is inside the previous DONE cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] strb, input bit b2b);
        exp_t e;
        int n;
        logic [3:0] eff;
        int idx;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = data; pstrb[d] = strb;
        eff = STRB_EN ? strb : 4'hF;
        idx = int'((a - BASE) / 4);
        e.err = !legal_m(a);
        e.data = '0;
        if (legal_m(a)) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (eff[b]) mem_m[d][idx][b*8 +: 8] = data[b*8 +: 8];
            end else begin
                e.data = mem_m[d][idx];
            end
        end
        push_exp(d, e);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready[d] && n < 40);
        chk($sformatf("access_cycles_dut%0d_%h", d, a), n, wc(d) + 1);
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    // Write that never completes: psel drops, or reset hits, after acc access cycles.
    task automatic xfer_abort(input int d, input logic [31:0] a, input logic [31:0] data,
                              input int acc, input bit by_reset);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
        paddr[d] = a; pwdata[d] = data; pstrb[d] = 4'hF;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        repeat (acc) @(posedge clk);
        #1;
        if (!by_reset) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
            repeat (3) @(posedge clk);
        end else begin
            #2;
            reset_n[d] = 1'b0;
            psel[d] = 1'b0; penable[d] = 1'b0;
            clear_model(d);
            @(negedge clk);
            chk("reset_prdata", prdata[d], 32'd0);
            chk("reset_pready", {31'b0, pready[d]}, 32'd0);
            chk("reset_pslverr", {31'b0, pslverr[d]}, 32'd0);
            @(posedge clk); #1;
            reset_n[d] = 1'b1;
            @(negedge clk);
            chk("post_reset_pready", {31'b0, pready[d]}, 32'd0);
            chk("post_reset_prdata", prdata[d], 32'd0);
        end
    endtask

    initial begin
        reset_n = 2'b00; psel = '0; penable = '0; pwrite = '0;
        paddr = '0; pwdata = '0; pstrb = '0;
        clear_model(0); clear_model(1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_prdata", prdata[d], 32'd0);
            chk("rst_pready", {31'b0, pready[d]}, 32'd0);
            chk("rst_pslverr", {31'b0, pslverr[d]}, 32'd0);
        end
        reset_n = 2'b11;

        // Basic write/read and wait-state latency.
        xfer(0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(0, 1'b0, 32'h1004, 32'h0, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
        xfer(1, 1'b1, 32'h1004, 32'h0BADF00D, 4'hF, 1'b0);

        // Illegal addresses, then a full read-back of both instances.
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 32'h1040, 32'h12345678, 4'hF, 1'b0);
            xfer(d, 1'b1, 32'h1002, 32'h87654321, 4'hF, 1'b0);
            xfer(d, 1'b1, 32'h0FFC, 32'hA5A5A5A5, 4'hF, 1'b0);
            xfer(d, 1'b0, 32'h1040, 32'h0, 4'hF, 1'b0);
            for (int i = 0; i < DEPTH; i++)
                xfer(d, 1'b0, BASE + 32'(4 * i), 32'h0, 4'hF, 1'b0);
        end

        // Byte-lane strobes (meaningful only when the strobe port exists).
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 32'h1008, 32'hFFFFFFFF, 4'hF, 1'b0);
            xfer(d, 1'b1, 32'h1008, 32'h11223344, 4'b0101, 1'b0);
            xfer(d, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0);
            xfer(d, 1'b1, 32'h1008, 32'h99999999, 4'b0000, 1'b0);
            xfer(d, 1'b0, 32'h1008, 32'h0, 4'hF, 1'b0);
        end

        // Back-to-back transfers, setup issued inside the previous DONE cycle.
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b1, 32'h1020, 32'hA1B2C3D4, 4'hF, 1'b0);
            xfer(d, 1'b0, 32'h1020, 32'h0, 4'hF, 1'b1);
            xfer(d, 1'b1, 32'h1024, 32'h5566_7788, 4'hF, 1'b1);
            xfer(d, 1'b0, 32'h1024, 32'h0, 4'hF, 1'b1);
            xfer(d, 1'b1, 32'h1020, 32'h0F0F_0F0F, 4'hF, 1'b1);
            xfer(d, 1'b0, 32'h1020, 32'h0, 4'hF, 1'b1);
        end

        // Abort by psel drop, then by reset, on the wait-state instance.
        xfer(1, 1'b1, 32'h1010, 32'h5555AAAA, 4'hF, 1'b0);
        xfer_abort(1, 32'h1010, 32'hCAFEF00D, 1, 1'b0);
        xfer(1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0);
        xfer_abort(1, 32'h1014, 32'hFEEDFACE, 2, 1'b1);
        xfer(1, 1'b0, 32'h1014, 32'h0, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h1010, 32'h0, 4'hF, 1'b0);
        xfer(1, 1'b0, 32'h1020, 32'h0, 4'hF, 1'b0);

        // Randomized traffic against the model.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 80; k++) begin
                int r;
                logic [31:0] a;
                r = int'($urandom_range(0, 9));
                if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                else if (r == 7) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                else if (r == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
                else             a = BASE - 32'(4 * $urandom_range(1, 4));
                xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
            end
        end

        repeat (4) @(posedge clk);
        chk("pending_dut0", 32'(q0.size()), 32'd0);
        chk("pending_dut1", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
